pipe_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage core. Collects stall requests from

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_if.sv | 35 +++
 rtl/pipe_mc_timer.sv | 39 +++
 rtl/pipe_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: state encodings,
// stall codes, multi-cycle kinds and bus widths.
package pipe_ctrl_pkg;

    localparam int RegBus      = 32;
    localparam int InstAddrBus = 32;
    localparam int CntW        = 6;
    localparam int StallW      = 6;

    // Stall vector bit order: {wb,mem,ex,id,if,pc}; 1 = hold stage.
    localparam logic [StallW-1:0] StallNone = 6'b000000;
    localparam logic [StallW-1:0] StallId   = 6'b000111;
    localparam logic [StallW-1:0] StallEx   = 6'b001111;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [InstAddrBus-1:0] ExcVector = 32'h0000_0020;

    typedef enum logic {
        MC_MADD = 1'b0,
        MC_DIV  = 1'b1
    } mc_kind_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_RUN  = 2'd1,
        MC_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
// All signals are level-sampled each cycle; outputs are combinational.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                   stallreq_id_i;
    logic                   mc_start_i;
    mc_kind_e               mc_kind_i;
    logic                   mc_cancel_i;
    logic                   except_i;
    logic                   eret_i;
    logic [InstAddrBus-1:0] epc_i;
    logic [StallW-1:0]      stall_o;
    logic                   flush_o;
    logic [InstAddrBus-1:0] new_pc_o;
    logic                   mc_busy_o;
    logic                   mc_done_o;
    state_e                 state_dbg;
    logic [CntW-1:0]        cnt_dbg;

    modport master (
        output stallreq_id_i, mc_start_i, mc_kind_i, mc_cancel_i,
               except_i, eret_i, epc_i,
        input  stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o,
               state_dbg, cnt_dbg
    );

    modport slave (
        input  stallreq_id_i, mc_start_i, mc_kind_i, mc_cancel_i,
               except_i, eret_i, epc_i,
        output stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o,
               state_dbg, cnt_dbg
    );

endinterface

// File: rtl/pipe_mc_timer.sv
// Loadable down-counter timing multi-cycle execute ops; saturates at zero.
module pipe_mc_timer
    import pipe_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            dec_i,
    input  logic            clr_i,
    output logic [CntW-1:0] cnt_o,
    output logic            zero_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates exception flush, multi-cycle execute stalls
// and decode load-use stalls into one stall vector and redirect.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                     DIV_CYCLES  = 32,
    parameter int                     MADD_CYCLES = 2,
    parameter logic [InstAddrBus-1:0] EXC_VECTOR  = ExcVector
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);

    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);
    localparam logic [CntW-1:0] MaddLoad = CntW'(MADD_CYCLES - 1);

    state_e          state_q, state_d;
    mc_kind_e        kind_q, kind_d;
    logic            tmr_load, tmr_dec, tmr_clr, tmr_zero;
    logic [CntW-1:0] tmr_cnt;

    pipe_mc_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i ((bus.mc_kind_i == MC_DIV) ? DivLoad : MaddLoad),
        .dec_i      (tmr_dec),
        .clr_i      (tmr_clr),
        .cnt_o      (tmr_cnt),
        .zero_o     (tmr_zero)
    );

    // Priority: rst > except > multi-cycle > decode hazard.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        tmr_clr      = 1'b0;
        bus.stall_o   = StallNone;
        bus.flush_o   = NoStop;
        bus.new_pc_o  = '0;
        bus.mc_busy_o = 1'b0;
        bus.mc_done_o = 1'b0;
        if (rst) begin
            state_d = IDLE;
        end else if (bus.except_i) begin
            bus.flush_o  = Stop;
            bus.new_pc_o = bus.eret_i ? bus.epc_i : EXC_VECTOR;
            state_d      = IDLE;
            tmr_clr      = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.mc_start_i) begin
                        tmr_load      = 1'b1;
                        kind_d        = bus.mc_kind_i;
                        bus.stall_o   = StallEx;
                        bus.mc_busy_o = 1'b1;
                        state_d       = MC_RUN;
                    end else if (bus.stallreq_id_i) begin
                        bus.stall_o = StallId;
                    end
                end
                MC_RUN: begin
                    bus.stall_o   = StallEx;
                    bus.mc_busy_o = 1'b1;
                    if (bus.mc_cancel_i) begin
                        tmr_clr = 1'b1;
                        state_d = IDLE;
                    end else if (tmr_zero) begin
                        state_d = MC_DONE;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                MC_DONE: begin
                    bus.mc_done_o = 1'b1;
                    bus.stall_o   = bus.stallreq_id_i ? StallId : StallNone;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            kind_q  <= MC_MADD;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
        end
    end

    assign bus.state_dbg = state_q;
    assign bus.cnt_dbg   = tmr_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, div, madd with decode hazard,
// exception/eret flush, cancel and ignored restarts.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .DIV_CYCLES  (32),
        .MADD_CYCLES (2),
        .EXC_VECTOR  (32'h0000_0020)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stallreq_id_i = 1'b0;
        bus.mc_start_i    = 1'b0;
        bus.mc_kind_i     = MC_MADD;
        bus.mc_cancel_i   = 1'b0;
        bus.except_i      = 1'b0;
        bus.eret_i        = 1'b0;
        bus.epc_i         = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stallreq_id_i = 1'b1;
        bus.mc_start_i    = 1'b1;
        bus.mc_kind_i     = MC_DIV;
        bus.mc_cancel_i   = 1'b1;
        bus.except_i      = 1'b1;
        bus.eret_i        = 1'b1;
        bus.epc_i         = 32'hdead_beef;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.stall_o, bus.flush_o, bus.new_pc_o, bus.mc_busy_o, bus.mc_done_o} !== '0) begin
                tests_failed++;
                $display("FAIL reset_outputs k=%0d: stall=%b flush=%b new_pc=%h busy=%b done=%b, want all 0",
                         k, bus.stall_o, bus.flush_o, bus.new_pc_o, bus.mc_busy_o, bus.mc_done_o);
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (bus.state_dbg !== IDLE || bus.cnt_dbg !== 6'd0 || bus.stall_o !== StallNone) begin
            tests_failed++;
            $display("FAIL reset_release: state=%0d cnt=%0d stall=%b, want IDLE/0/000000",
                     bus.state_dbg, bus.cnt_dbg, bus.stall_o);
        end
        tick();
    endtask

    task automatic test_id_stall();
        bus.stallreq_id_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.stall_o !== 6'b000111 || bus.flush_o !== 1'b0 || bus.mc_busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL id_stall: stall=%b flush=%b busy=%b, want 000111/0/0",
                     bus.stall_o, bus.flush_o, bus.mc_busy_o);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_div();
        logic [5:0] exp_stall;
        for (int k = 0; k <= 34; k++) begin
            bus.mc_start_i = (k == 0);
            bus.mc_kind_i  = MC_DIV;
            exp_stall = (k <= 32) ? 6'b001111 : 6'b000000;
            @(negedge clk);
            tests_run++;
            if (bus.stall_o !== exp_stall || bus.mc_done_o !== (k == 33) || bus.mc_busy_o !== (k <= 32)) begin
                tests_failed++;
                $display("FAIL div k=%0d: stall=%b done=%b busy=%b, want %b/%b/%b",
                         k, bus.stall_o, bus.mc_done_o, bus.mc_busy_o, exp_stall, k == 33, k <= 32);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_madd_id();
        logic [5:0] exp_stall;
        for (int k = 0; k <= 5; k++) begin
            bus.mc_start_i    = (k == 0);
            bus.mc_kind_i     = MC_MADD;
            bus.stallreq_id_i = (k <= 4);
            exp_stall = (k <= 2) ? 6'b001111 : (k <= 4) ? 6'b000111 : 6'b000000;
            @(negedge clk);
            tests_run++;
            if (bus.stall_o !== exp_stall || bus.mc_done_o !== (k == 3)) begin
                tests_failed++;
                $display("FAIL madd_id k=%0d: stall=%b done=%b, want %b/%b",
                         k, bus.stall_o, bus.mc_done_o, exp_stall, k == 3);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_except_div();
        for (int k = 0; k <= 40; k++) begin
            bus.mc_start_i = (k == 0);
            bus.mc_kind_i  = MC_DIV;
            bus.except_i   = (k == 5);
            @(negedge clk);
            tests_run++;
            if (k == 5) begin
                if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h20 || bus.stall_o !== 6'b0) begin
                    tests_failed++;
                    $display("FAIL except_div flush: flush=%b new_pc=%h stall=%b, want 1/00000020/000000",
                             bus.flush_o, bus.new_pc_o, bus.stall_o);
                end
            end else if (k < 5) begin
                if (bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0 || bus.stall_o !== 6'b001111) begin
                    tests_failed++;
                    $display("FAIL except_div pre k=%0d: flush=%b new_pc=%h stall=%b, want 0/0/001111",
                             k, bus.flush_o, bus.new_pc_o, bus.stall_o);
                end
            end else begin
                if (bus.flush_o !== 1'b0 || bus.stall_o !== 6'b0 || bus.mc_done_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL except_div post k=%0d: flush=%b stall=%b done=%b, want 0/000000/0",
                             k, bus.flush_o, bus.stall_o, bus.mc_done_o);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_eret();
        bus.except_i = 1'b1;
        bus.eret_i   = 1'b1;
        bus.epc_i    = 32'h0000_0104;
        @(negedge clk);
        tests_run++;
        if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h104) begin
            tests_failed++;
            $display("FAIL eret: flush=%b new_pc=%h, want 1/00000104", bus.flush_o, bus.new_pc_o);
        end
        tick();
        idle_inputs();
        bus.epc_i = 32'h0000_0104;
        @(negedge clk);
        tests_run++;
        if (bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL eret_after: flush=%b new_pc=%h, want 0/00000000", bus.flush_o, bus.new_pc_o);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_except_start();
        bus.except_i   = 1'b1;
        bus.mc_start_i = 1'b1;
        bus.mc_kind_i  = MC_DIV;
        @(negedge clk);
        tests_run++;
        if (bus.flush_o !== 1'b1 || bus.stall_o !== 6'b0 || bus.mc_busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL except_start: flush=%b stall=%b busy=%b, want 1/000000/0",
                     bus.flush_o, bus.stall_o, bus.mc_busy_o);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (bus.state_dbg !== IDLE || bus.stall_o !== 6'b0 || bus.mc_busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL except_start_next: state=%0d stall=%b busy=%b, want IDLE/000000/0",
                     bus.state_dbg, bus.stall_o, bus.mc_busy_o);
        end
        tick();
    endtask

    task automatic test_cancel();
        logic [5:0] exp_stall;
        for (int k = 0; k <= 40; k++) begin
            bus.mc_start_i  = (k == 0);
            bus.mc_kind_i   = MC_DIV;
            bus.mc_cancel_i = (k == 3) || (k == 10);
            exp_stall = (k <= 3) ? 6'b001111 : 6'b000000;
            @(negedge clk);
            tests_run++;
            if (bus.stall_o !== exp_stall || bus.mc_done_o !== 1'b0 || bus.mc_busy_o !== (k <= 3)) begin
                tests_failed++;
                $display("FAIL cancel k=%0d: stall=%b done=%b busy=%b, want %b/0/%b",
                         k, bus.stall_o, bus.mc_done_o, bus.mc_busy_o, exp_stall, k <= 3);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_stall;
        for (int k = 0; k <= 5; k++) begin
            // Restart during MC_RUN and MC_DONE must both be ignored.
            bus.mc_start_i = (k == 0) || (k == 1) || (k == 3);
            bus.mc_kind_i  = (k == 0) ? MC_MADD : MC_DIV;
            exp_stall = (k <= 2) ? 6'b001111 : 6'b000000;
            @(negedge clk);
            tests_run++;
            if (bus.stall_o !== exp_stall || bus.mc_done_o !== (k == 3) || bus.mc_busy_o !== (k <= 2)) begin
                tests_failed++;
                $display("FAIL back_to_back k=%0d: stall=%b done=%b busy=%b, want %b/%b/%b",
                         k, bus.stall_o, bus.mc_done_o, bus.mc_busy_o, exp_stall, k == 3, k <= 2);
            end
            if (k == 1) begin
                tests_run++;
                if (bus.cnt_dbg !== 6'd1) begin
                    tests_failed++;
                    $display("FAIL back_to_back_cnt: cnt=%0d, want 1", bus.cnt_dbg);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_id_stall();
        test_div();
        test_madd_id();
        test_except_div();
        test_eret();
        test_except_start();
        test_cancel();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
